sdwr_tx: RTL and testbench
==========================

SDWR_TX -- requirements
Module: sdwr_tx

Interface
REQ-001 Parameter CLKDIV, default 4: system clocks per serial-clock half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 SSER  input  1  serial-port select; active low.
REQ-005 BA13, BA12  input  1 each  bus address decode bits; block selected when BA13=0, BA12=1.
REQ-006 BA7..BA4  input  4  register select within the block.
REQ-007 BR_W  input  1  bus direction; 1=read, 0=write.
REQ-008 BD  input  8  bus write data.
REQ-009 SDWR  output  1  serial data out to device, MSB first.
REQ-010 SCLK  output  1  serial clock to device.
REQ-011 SCS  output  1  device chip select; active high.
REQ-012 BUSY  output  1  high while a transfer is in progress.
REQ-013 OVR  output  1  sticky overrun flag.

Function
REQ-014 The block SHALL register a bus write when SSER=0, BA13=0, BA12=1 and BR_W=0 are all true in one clk cycle; each cycle of such a condition is one write.
REQ-015 The block SHALL decode writes by BA7..BA4: 0x0 = DATA, 0x1 = CTRL, 0x2 = CLR; other values SHALL be ignored.
REQ-016 A CTRL write SHALL set SCS=BD[0] and the start-bit enable SB=BD[1] on the next clk edge, only while BUSY=0.
REQ-017 A DATA write with BUSY=0 SHALL load BD into the shift register, clear the bit counter and enter START (SB=1) or SHIFT (SB=0), with BUSY=1 from the next cycle.
REQ-018 A DATA or CTRL write with BUSY=1 SHALL be discarded and SHALL set OVR=1.
REQ-019 A CLR write SHALL clear OVR in any state; if CLR and an overrun-setting write coincide, set wins (only possible across separate cycles, so order by cycle).
REQ-020 FSM states: IDLE, START, SHIFT, DONE; transitions IDLE->START/SHIFT on DATA write, START->SHIFT after one bit period, SHIFT->DONE after 8 bit periods, DONE->IDLE after one clk.
REQ-021 One bit period SHALL be 2*CLKDIV clks: SCLK=0 for the first CLKDIV, SCLK=1 for the second; SDWR SHALL change only at the start of a bit period (SCLK low phase).
REQ-022 In START, SDWR SHALL be 1 (Microwire start bit); in SHIFT, SDWR SHALL present shift-register bit 7, shifting left by one at each bit-period end.
REQ-023 A byte transfer SHALL take exactly 8*2*CLKDIV clks (plus 2*CLKDIV with SB=1) from the cycle after the DATA write to entry into DONE.
REQ-024 In IDLE and DONE, SCLK SHALL be 0 and SDWR SHALL hold its last driven value; SCS SHALL be unaffected by transfers.
REQ-025 BUSY SHALL be 1 in START, SHIFT and DONE, and 0 in IDLE, so a DATA write is accepted on the first IDLE cycle.
REQ-026 Bus read cycles (BR_W=1) SHALL have no effect on any state.

Reset
REQ-027 rst_n=0 on a clk edge SHALL force IDLE, SCLK=0, SDWR=0, SCS=0, SB=0, BUSY=0, OVR=0, counters=0, aborting any transfer mid-bit.
REQ-028 Reset SHALL take precedence over a simultaneous bus write.

Structure
REQ-029 The FSM state enumeration and register-select constants (DATA=0x0, CTRL=0x1, CLR=0x2) SHALL reside in shared package sdwr_pkg.
REQ-030 The half-period divider SHALL be one sub-module, sdwr_clkdiv, emitting a one-clk tick at each SCLK phase boundary, held cleared while IDLE.
REQ-031 All outputs SHALL be driven directly from registers.

Verification
REQ-032 CLKDIV=4, CTRL write BD=0x01, DATA write BD=0xA5 -> SCS=1, SDWR bits 1,0,1,0,0,1,0,1, 8 SCLK pulses each 4 clks high, BUSY low 65 clks after write.
REQ-033 CTRL BD=0x03 then DATA BD=0x00 -> leading SDWR=1 start bit, then eight 0 bits, 9 SCLK pulses, BUSY high 73 clks.
REQ-034 DATA write 0xFF, second DATA write 0x00 during SHIFT -> transmitted byte stays 0xFF, OVR=1; CLR write -> OVR=0.
REQ-035 rst_n=0 during bit 3 of a transfer -> next cycle SCLK=0, SDWR=0, BUSY=0, SCS=0; fresh DATA write 0x3C transmits correctly.
REQ-036 Write with SSER=1, or BA13=1, or BA7..BA4=0x5, or BR_W=1 -> no state change, BUSY stays 0.

Source files
------------

// File: rtl/sdwr_pkg.sv
// Shared types and constants for the serial write transmitter.
// Holds the FSM encoding and the register-select codes decoded from BA7..BA4.
package sdwr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] REG_DATA = 4'h0;
    localparam logic [3:0] REG_CTRL = 4'h1;
    localparam logic [3:0] REG_CLR  = 4'h2;

endpackage

// File: rtl/sdwr_tx_if.sv
// Bus and serial-line signals of the transmitter, bundled for port connection.
// BA carries address bits BA7..BA4; the master side is the host bus.
interface sdwr_tx_if;

    // Bus handshake: a write is a single clk cycle with SSER=0, BA13=0, BA12=1,
    // BR_W=0; there is no ready, and writes arriving while BUSY=1 are dropped
    // and flagged on OVR.
    logic       SSER;
    logic       BA13;
    logic       BA12;
    logic [3:0] BA;
    logic       BR_W;
    logic [7:0] BD;
    logic       SDWR;
    logic       SCLK;
    logic       SCS;
    logic       BUSY;
    logic       OVR;

    modport master (
        output SSER, BA13, BA12, BA, BR_W, BD,
        input  SDWR, SCLK, SCS, BUSY, OVR
    );

    modport slave (
        input  SSER, BA13, BA12, BA, BR_W, BD,
        output SDWR, SCLK, SCS, BUSY, OVR
    );

endinterface

// File: rtl/sdwr_clkdiv.sv
// Half-period divider: one-clk tick on the last clk of every SCLK phase.
// The count is held at zero whenever en is low, so every transfer starts aligned.
module sdwr_clkdiv #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sdwr_tx.sv
// Microwire-style serial write transmitter: bus-loaded byte shifted out MSB first,
// with an optional leading start bit, device chip select and sticky overrun flag.
module sdwr_tx
    import sdwr_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sdwr_tx_if.slave    bus,
    output state_t      dbg_state
);

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       sdwr, sdwr_n;
    logic       sclk, sclk_n;
    logic       scs, scs_n;
    logic       sb, sb_n;
    logic       busy, busy_n;
    logic       ovr, ovr_n;
    logic       tick;
    logic       div_en;
    logic       wr, wr_data, wr_ctrl, wr_clr;

    assign wr      = !bus.SSER && !bus.BA13 && bus.BA12 && !bus.BR_W;
    assign wr_data = wr && (bus.BA == REG_DATA);
    assign wr_ctrl = wr && (bus.BA == REG_CTRL);
    assign wr_clr  = wr && (bus.BA == REG_CLR);
    assign div_en  = (state == START) || (state == SHIFT);

    sdwr_clkdiv #(.CLKDIV(CLKDIV)) u_clkdiv (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sdwr    <= 1'b0;
            sclk    <= 1'b0;
            scs     <= 1'b0;
            sb      <= 1'b0;
            busy    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            sdwr    <= sdwr_n;
            sclk    <= sclk_n;
            scs     <= scs_n;
            sb      <= sb_n;
            busy    <= busy_n;
            ovr     <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        sdwr_n    = sdwr;
        sclk_n    = sclk;
        scs_n     = scs;
        sb_n      = sb;
        ovr_n     = ovr;

        // Only one register select per cycle, so clear and set never collide.
        if (wr_clr) begin
            ovr_n = 1'b0;
        end
        if ((wr_data || wr_ctrl) && (state != IDLE)) begin
            ovr_n = 1'b1;
        end
        if (wr_ctrl && (state == IDLE)) begin
            scs_n = bus.BD[0];
            sb_n  = bus.BD[1];
        end

        case (state)
            IDLE: begin
                if (wr_data) begin
                    shreg_n   = bus.BD;
                    bit_cnt_n = '0;
                    sclk_n    = 1'b0;
                    if (sb) begin
                        state_n = START;
                        sdwr_n  = 1'b1;
                    end else begin
                        state_n = SHIFT;
                        sdwr_n  = bus.BD[7];
                    end
                end
            end
            START: begin
                if (tick) begin
                    sclk_n = !sclk;
                    if (sclk) begin
                        state_n = SHIFT;
                        sdwr_n  = shreg[7];
                    end
                end
            end
            SHIFT: begin
                // A tick while SCLK is high closes the bit period.
                if (tick) begin
                    sclk_n = !sclk;
                    if (sclk) begin
                        shreg_n   = {shreg[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = DONE;
                        end else begin
                            sdwr_n = shreg[6];
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                sclk_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.SDWR  = sdwr;
    assign bus.SCLK  = sclk;
    assign bus.SCS   = scs;
    assign bus.BUSY  = busy;
    assign bus.OVR   = ovr;
    assign dbg_state = state;

endmodule

// File: tb/tb_sdwr_tx.sv
// Bench for sdwr_tx: transfer-level model queues expected serial bits and BUSY
// lengths; a negedge monitor pops them as SCLK pulses and BUSY windows appear.
module tb_sdwr_tx;
    import sdwr_pkg::*;

    localparam int CLKDIV = 4;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdwr_tx_if bus ();

    sdwr_tx #(.CLKDIV(CLKDIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [0:0] exp_q[$];
    int         exp_busy_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       exp_scs = 1'b0;
    logic       exp_sb  = 1'b0;
    logic       exp_ovr = 1'b0;
    logic       last_bit = 1'b0;
    int         busy_end = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transfer model: bit list and BUSY length follow directly from the byte,
    // the start-bit enable and the bit period of 2*CLKDIV clks.
    task automatic model_write(input logic [3:0] sel, input logic [7:0] data, input int edge_no);
        logic busy_now;
        int   len;
        busy_now = (edge_no <= busy_end);
        case (sel)
            REG_DATA: begin
                if (busy_now) begin
                    exp_ovr = 1'b1;
                end else begin
                    if (exp_sb) exp_q.push_back(1'b1);
                    for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
                    len = (exp_sb ? 9 : 8) * 2 * CLKDIV + 1;
                    exp_busy_q.push_back(len);
                    busy_end = edge_no + len;
                    last_bit = data[0];
                end
            end
            REG_CTRL: begin
                if (busy_now) begin
                    exp_ovr = 1'b1;
                end else begin
                    exp_scs = data[0];
                    exp_sb  = data[1];
                end
            end
            REG_CLR: exp_ovr = 1'b0;
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.SSER = 1'b1;
        bus.BA13 = 1'b0;
        bus.BA12 = 1'b1;
        bus.BA   = 4'h0;
        bus.BR_W = 1'b1;
        bus.BD   = 8'h00;
    endtask

    task automatic raw_write(input logic [3:0] sel, input logic [7:0] data,
                             input logic sser, input logic ba13, input logic ba12, input logic br_w);
        @(negedge clk);
        bus.SSER = sser;
        bus.BA13 = ba13;
        bus.BA12 = ba12;
        bus.BA   = sel;
        bus.BR_W = br_w;
        bus.BD   = data;
        @(negedge clk);
        drive_idle();
    endtask

    // now=1 drives at the current negedge (used right after wait_idle).
    task automatic do_write(input logic [3:0] sel, input logic [7:0] data, input bit now = 1'b0);
        if (!now) @(negedge clk);
        bus.SSER = 1'b0;
        bus.BA13 = 1'b0;
        bus.BA12 = 1'b1;
        bus.BA   = sel;
        bus.BR_W = 1'b0;
        bus.BD   = data;
        model_write(sel, data, cyc + 1);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.BUSY) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_idle: BUSY still 1 after 3000 clks, expected 0");
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_sclk", bus.SCLK, 0);
        check("rst_sdwr", bus.SDWR, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_scs", bus.SCS, 0);
        check("rst_ovr", bus.OVR, 0);
        check("rst_state", dbg_state, IDLE);
        exp_q.delete();
        exp_busy_q.delete();
        exp_scs  = 1'b0;
        exp_sb   = 1'b0;
        exp_ovr  = 1'b0;
        last_bit = 1'b0;
        busy_end = -1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic prev_sclk = 1'b0;
    logic prev_busy = 1'b0;
    int   hi_cnt = 0;
    int   busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0;
            prev_busy = 1'b0;
            hi_cnt    = 0;
            busy_cnt  = 0;
        end else begin
            if (bus.SCLK && !prev_sclk) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sdwr_bit: SCLK pulse with SDWR=%0b, expected no pulse", bus.SDWR);
                end else begin
                    check("sdwr_bit", bus.SDWR, exp_q.pop_front());
                end
            end
            if (bus.SCLK) begin
                hi_cnt++;
            end else if (prev_sclk) begin
                check("sclk_high_clks", hi_cnt, CLKDIV);
                hi_cnt = 0;
            end
            if (bus.BUSY) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_busy_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL busy_clks: BUSY window of %0d clks, expected none", busy_cnt);
                end else begin
                    check("busy_clks", busy_cnt, exp_busy_q.pop_front());
                end
                busy_cnt = 0;
            end
            prev_sclk = bus.SCLK;
            prev_busy = bus.BUSY;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        logic [1:0] c;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("init_sclk", bus.SCLK, 0);
        check("init_sdwr", bus.SDWR, 0);
        check("init_busy", bus.BUSY, 0);
        check("init_scs", bus.SCS, 0);
        check("init_ovr", bus.OVR, 0);
        check("init_state", dbg_state, IDLE);
        rst_n = 1'b1;

        // Plain byte, chip select on.
        do_write(REG_CTRL, 8'h01);
        do_write(REG_DATA, 8'hA5);
        check("a5_scs", bus.SCS, 1);
        check("a5_busy", bus.BUSY, 1);
        wait_idle();
        check("a5_sdwr_hold", bus.SDWR, last_bit);

        // Start bit enabled, all-zero byte.
        do_write(REG_CTRL, 8'h03);
        do_write(REG_DATA, 8'h00);
        wait_idle();
        check("00_sdwr_hold", bus.SDWR, last_bit);

        // Overrun during SHIFT, then clear.
        do_write(REG_CTRL, 8'h01);
        do_write(REG_DATA, 8'hFF);
        repeat (20) @(negedge clk);
        do_write(REG_DATA, 8'h00);
        check("ovr_data", bus.OVR, exp_ovr);
        do_write(REG_CTRL, 8'h00);
        check("ovr_ctrl_scs", bus.SCS, exp_scs);
        wait_idle();
        check("ovr_sticky", bus.OVR, 1);
        do_write(REG_CLR, 8'h00);
        check("ovr_clr", bus.OVR, exp_ovr);

        // Reset while SCLK is high in bit 3, then a fresh transfer.
        do_write(REG_DATA, 8'h5A);
        repeat (3 * 2 * CLKDIV + CLKDIV + 1) @(negedge clk);
        check("pre_rst_sclk", bus.SCLK, 1);
        apply_reset();
        do_write(REG_DATA, 8'h3C);
        wait_idle();
        check("3c_sdwr_hold", bus.SDWR, last_bit);

        // Non-decoded or read cycles must be ignored.
        raw_write(REG_DATA, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        raw_write(REG_DATA, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        raw_write(4'h5,     8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        raw_write(REG_DATA, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        raw_write(REG_CTRL, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        raw_write(REG_CTRL, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("ign_busy", bus.BUSY, 0);
        check("ign_state", dbg_state, IDLE);
        check("ign_scs", bus.SCS, exp_scs);
        check("ign_ovr", bus.OVR, exp_ovr);

        // Randomized transfers, sometimes back-to-back and with overruns.
        for (int t = 0; t < 14; t++) begin
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            do_write(REG_CTRL, {6'b0, c}, bit'($urandom_range(0, 1)));
            check("rnd_scs", bus.SCS, exp_scs);
            do_write(REG_DATA, d);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 40)) @(negedge clk);
                do_write($urandom_range(0, 1) ? REG_DATA : REG_CTRL, 8'($urandom_range(0, 255)));
                check("rnd_ovr", bus.OVR, exp_ovr);
                check("rnd_ovr_scs", bus.SCS, exp_scs);
            end
            wait_idle();
            check("rnd_sdwr_hold", bus.SDWR, last_bit);
            if ($urandom_range(0, 1) == 0) begin
                do_write(REG_CLR, 8'h00, 1'b1);
                check("rnd_clr", bus.OVR, exp_ovr);
            end
        end

        repeat (5) @(negedge clk);
        check("bits_left", exp_q.size(), 0);
        check("busy_left", exp_busy_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
